// File: rtl/dbfs_log2_atten.sv
// dbfs_log2_atten: attenuation below full scale in octaves, log2(2^(IN_W-1)/|x|),
// by normalising |x| and then extracting log2 of the mantissa one bit per squaring.
module dbfs_log2_atten #(
   parameter int IN_W   = 24,
   parameter int INT_W  = 5,
   parameter int FRAC_W = 33,
   parameter int GUARD  = 4,
   localparam int OUT_W = INT_W + FRAC_W,
   localparam int MW    = FRAC_W + GUARD
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_atten,
   output logic             out_zero,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int CW = $clog2(FRAC_W + 1);
   typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;
   state_t            state_q;
   logic              rdy_q;
   logic              out_valid_q;
   logic              zero_q;
   logic [OUT_W-1:0]  atten_q;
   logic [IN_W-1:0]   a_q;
   logic [MW:0]       m_q;
   logic [FRAC_W-1:0] frac_q;
   logic [CW-1:0]     cnt_q;
   logic [INT_W-1:0]  sh_q;
   logic [IN_W-1:0]   mag;
   logic [INT_W-1:0]  lz;
   logic [IN_W-1:0]   a_n;
   logic [2*MW+1:0]   mw;
   logic [2*MW+1:0]   sq;
   logic [MW:0]       m_d;
   logic [FRAC_W-1:0] frac_d;
   assign mag = in_data[IN_W-1] ? -in_data : in_data;
   always_comb begin
      lz = '0;
      for (int i = 0; i < IN_W; i++)
         if (a_q[i]) lz = INT_W'(IN_W - 1 - i);
   end
   assign a_n = a_q << lz;
   assign mw  = (2*MW+2)'(m_q);
   assign sq  = mw * mw;
   // A square >= 2 yields a 1 bit and is halved back into [1,2).
   assign m_d    = sq[2*MW+1] ? (MW+1)'(sq >> (MW + 1)) : (MW+1)'(sq >> MW);
   assign frac_d = {frac_q[FRAC_W-2:0], sq[2*MW+1]};
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         atten_q     <= '0;
         a_q         <= '0;
         m_q         <= '0;
         frac_q      <= '0;
         cnt_q       <= '0;
         sh_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               rdy_q <= 1'b1;
               if (rdy_q && in_valid) begin
                  a_q     <= mag;
                  rdy_q   <= 1'b0;
                  state_q <= NORM;
               end
            end
            NORM: begin
               zero_q <= a_q == '0;
               if (a_q == '0) begin
                  atten_q <= '1;
                  state_q <= DONE;
               end else begin
                  m_q     <= {a_n, (MW+1-IN_W)'(0)};
                  sh_q    <= lz;
                  frac_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= ITER;
               end
            end
            ITER: begin
               m_q    <= m_d;
               frac_q <= frac_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(FRAC_W - 1)) state_q <= DONE;
            end
            DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  if (!zero_q) atten_q <= {sh_q, FRAC_W'(0)} - OUT_W'(frac_q);
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  rdy_q       <= 1'b1;
                  state_q     <= IDLE;
               end
            end
         endcase
      end
   assign in_ready  = rdy_q;
   assign out_valid = out_valid_q;
   assign out_atten = atten_q;
   assign out_zero  = zero_q;
endmodule

// File: tb/tb_dbfs_log2_atten.sv
// tb_dbfs_log2_atten: directed corner cases plus randomised handshaking traffic
// checked against a real-valued log2 model through an in-order queue.
module tb_dbfs_log2_atten;
   localparam int IN_W = 24, OUT_W = 38, N = 1200;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [OUT_W-1:0] out_atten;
   logic             out_zero;
   logic             out_valid;
   logic             out_ready = 1'b0;
   int               errors = 0;
   int               checks = 0;
   logic [IN_W-1:0]  q[$];
   always #5 clk = ~clk;
   dbfs_log2_atten dut (
      .ap_clk(clk), .ap_rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_atten(out_atten), .out_zero(out_zero), .out_valid(out_valid), .out_ready(out_ready)
   );
   task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
      longint d;
      d = got > exp ? got - exp : exp - got;
      checks++;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h (tol %0d)", tag, got, exp, tol);
      end
   endtask
   function automatic longint model(input logic [IN_W-1:0] x);
      longint mag;
      mag = x[IN_W-1] ? (longint'(1) << IN_W) - longint'(x) : longint'(x);
      return longint'((real'(IN_W - 1) - $ln(real'(mag)) / $ln(2.0)) * 8589934592.0);
   endfunction
   function automatic logic [IN_W-1:0] rnd();
      logic [IN_W-1:0] x;
      x = IN_W'($urandom & ((32'd1 << $urandom_range(1, IN_W)) - 1));
      if ($urandom_range(0, 1) == 1) x = -x;
      if (x == '0) x = 1;
      return x;
   endfunction
   task automatic send(input logic [IN_W-1:0] x);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
      in_data  = x;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic take(input string tag, input longint exp, input logic ez);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_atten"}, out_atten, exp);
      check({tag, "_zero"}, out_zero, ez);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_drop"}, out_valid, 0);
      check({tag, "_rdy"}, in_ready, 1);
   endtask
   initial begin
      #15_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n;
      int seen;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_atten", out_atten, 0);
      check("rst_zero", out_zero, 0);
      check("rst_rdy", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rdy_rel", in_ready, 1);
      send(24'h400000);
      wait_valid(n);
      check("t1_lat", n, 35);
      take("t1", 64'h0200000000, 1'b0);
      send(24'h800000);
      wait_valid(n);
      take("t2_neg", 64'h0, 1'b0);
      send(24'h000001);
      wait_valid(n);
      take("t2_one", 64'h2E00000000, 1'b0);
      send(24'hFFF000);
      wait_valid(n);
      take("t2_m4096", 64'h1600000000, 1'b0);
      send(24'h000000);
      wait_valid(n);
      check("t3_lat", n, 2);
      take("t3", 64'h3FFFFFFFFF, 1'b1);
      send(24'h7FFFFF);
      wait_valid(n);
      check("max_atten", out_atten, model(24'h7FFFFF), 4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      send(24'h100000);
      wait_valid(n);
      repeat (10) begin
         check("t4_valid", out_valid, 1);
         check("t4_atten", out_atten, 64'h0600000000);
         check("t4_zero", out_zero, 0);
         check("t4_rdy", in_ready, 0);
         @(negedge clk);
      end
      take("t4", 64'h0600000000, 1'b0);
      send(24'h123456);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_rdy", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t5_rdy_rel", in_ready, 1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         seen |= int'(out_valid);
      end
      check("t5_no_out", seen, 0);
      send(24'h200000);
      wait_valid(n);
      take("t5", 64'h0400000000, 1'b0);
      fork
         begin
            int sent = 0;
            int cyc = 0;
            logic acc = 1'b0;
            while ((sent < N || acc) && cyc < 80000) begin
               @(negedge clk);
               cyc++;
               if (acc) begin
                  in_valid = 1'b0;
                  acc = 1'b0;
               end
               if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                  in_data  = rnd();
                  in_valid = 1'b1;
               end
               if (in_valid && in_ready) begin
                  q.push_back(in_data);
                  sent++;
                  acc = 1'b1;
               end
            end
            check("rnd_sent", sent, N);
         end
         begin
            int got = 0;
            int cyc = 0;
            logic [IN_W-1:0] x;
            while (got < N && cyc < 80000) begin
               @(negedge clk);
               cyc++;
               out_ready = $urandom_range(0, 1) == 1;
               if (out_valid && out_ready) begin
                  check("rnd_qsize", longint'(q.size() > 0), 1);
                  if (q.size() > 0) begin
                     x = q.pop_front();
                     check("rnd_atten", out_atten, model(x), 4);
                     check("rnd_zero", out_zero, 0);
                  end
                  got++;
               end
            end
            @(negedge clk);
            out_ready = 1'b0;
            check("rnd_got", got, N);
         end
      join
      check("rnd_q_left", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
